// File: rtl/key_sw_dev_pkg.sv
// Shared definitions for the KEY/SW input-device responder: register
// addresses, control-bit layout and the control-register update rule.
package key_sw_dev_pkg;

    localparam logic [15:0] DEV_KDATA = 16'hFFF0;
    localparam logic [15:0] DEV_SDATA = 16'hFFF2;
    localparam logic [15:0] DEV_KCTRL = 16'hFFF4;
    localparam logic [15:0] DEV_SCTRL = 16'hFFF6;

    localparam int CTRL_RDY = 0;
    localparam int CTRL_OVR = 2;
    localparam int CTRL_IE  = 4;

    // Register index taken from address bits [2:1] inside the device window.
    typedef enum logic [1:0] {
        REG_KDATA = 2'd0,
        REG_SDATA = 2'd1,
        REG_KCTRL = 2'd2,
        REG_SCTRL = 2'd3
    } reg_sel_e;

    typedef struct packed {
        logic ie;
        logic ovr;
        logic rdy;
    } ctrl_t;

    // Pack a control register into its bus layout.
    function automatic logic [15:0] ctrl_word(input ctrl_t c);
        logic [15:0] w;
        w           = '0;
        w[CTRL_RDY] = c.rdy;
        w[CTRL_OVR] = c.ovr;
        w[CTRL_IE]  = c.ie;
        return w;
    endfunction

    // Next state of one control register. A change event always wins over a
    // simultaneous clear of RDY; OVR is only set when an unread value is lost.
    function automatic ctrl_t ctrl_next(input ctrl_t cur,
                                        input logic  change,
                                        input logic  rd_clr,
                                        input logic  wr,
                                        input logic  wr_rdy,
                                        input logic  wr_ovr,
                                        input logic  wr_ie);
        ctrl_t nxt;
        logic  rdy_clr;
        logic  ovr_clr;
        nxt     = cur;
        rdy_clr = rd_clr | (wr & ~wr_rdy);
        ovr_clr = rd_clr | (wr & ~wr_ovr);
        if (wr) begin
            nxt.ie = wr_ie;
        end
        if (change) begin
            if (cur.rdy && !rdy_clr) begin
                nxt.ovr = 1'b1;
            end
            nxt.rdy = 1'b1;
        end else begin
            if (rdy_clr) nxt.rdy = 1'b0;
            if (ovr_clr) nxt.ovr = 1'b0;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/key_sw_dev_if.sv
// CPU data-bus port of the input device: zero-wait load/store, no stall.
interface key_sw_dev_if #(
    parameter int DBITS = 16
) ();

    logic [DBITS-1:0] addr;
    logic [DBITS-1:0] din;
    logic             we;
    logic             re;
    logic [DBITS-1:0] dout;
    logic             sel;

    modport master (
        output addr, din, we, re,
        input  dout, sel
    );

    modport slave (
        input  addr, din, we, re,
        output dout, sel
    );

endinterface

// File: rtl/key_sw_dev_debounce_group.sv
// One debounced input group: 2-flop synchroniser, candidate register,
// stability counter and committed value. `change` is high for the single
// cycle whose closing edge commits a new value.
module debounce_group #(
    parameter int W          = 4,
    parameter int DEB_CYCLES = 500000,
    parameter int CBITS      = 20
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] raw,
    output logic [W-1:0] data,
    output logic         change
);

    logic [W-1:0]     sync1;
    logic [W-1:0]     sync2;
    logic [W-1:0]     cand;
    logic [CBITS-1:0] cnt;
    logic             cnt_full;

    assign cnt_full = (cnt == CBITS'(DEB_CYCLES - 1));
    assign change   = (sync2 == cand) && cnt_full && (cand != data);

    // Synchronise, track the candidate, count stable samples, commit.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments let every flop see pre-edge values, so the synchroniser stages shift instead of collapsing.
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            cand  <= '0;
            cnt   <= '0;
            data  <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 != cand) begin
                cand <= sync2;
                cnt  <= '0;
            end else if (change) begin
                data <= cand;
            end else if (!cnt_full) begin
                cnt <= cnt + CBITS'(1);
            end
        end
    end

endmodule

// File: rtl/key_sw_dev.sv
// Memory-mapped KEY/SW responder at FFF0..FFF6: debounced data registers,
// sticky ready/overrun flags, interrupt enables and a registered IRQ.
module key_sw_dev
    import key_sw_dev_pkg::*;
#(
    parameter int DBITS      = 16,
    parameter int DEB_CYCLES = 500000,
    parameter int CBITS      = 20
) (
    input  logic               clk,
    input  logic               reset_n,
    key_sw_dev_if.slave        bus,
    input  logic [3:0]         key,
    input  logic [9:0]         sw,
    output logic               irq
);

    logic [3:0]       kdata;
    logic [9:0]       sdata;
    logic             k_change;
    logic             s_change;
    ctrl_t            kctrl;
    ctrl_t            sctrl;
    ctrl_t            kctrl_n;
    ctrl_t            sctrl_n;
    logic             in_range;
    reg_sel_e         rsel;
    logic             k_rd_clr;
    logic             s_rd_clr;
    logic             k_wr;
    logic             s_wr;
    logic [DBITS-1:0] dout_c;
    logic             unused_din;

    // Keys are active-low at the pin; invert so 1 means pressed.
    debounce_group #(
        .W          (4),
        .DEB_CYCLES (DEB_CYCLES),
        .CBITS      (CBITS)
    ) u_keys (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (~key),
        .data    (kdata),
        .change  (k_change)
    );

    debounce_group #(
        .W          (10),
        .DEB_CYCLES (DEB_CYCLES),
        .CBITS      (CBITS)
    ) u_sws (
        .clk     (clk),
        .reset_n (reset_n),
        .raw     (sw),
        .data    (sdata),
        .change  (s_change)
    );

    assign in_range = (bus.addr >= DBITS'(DEV_KDATA)) && (bus.addr <= DBITS'(DEV_SCTRL));
    assign rsel     = reg_sel_e'(bus.addr[2:1]);
    assign bus.sel  = in_range;

    assign k_rd_clr = bus.re && in_range && (rsel == REG_KDATA);
    assign s_rd_clr = bus.re && in_range && (rsel == REG_SDATA);
    assign k_wr     = bus.we && in_range && (rsel == REG_KCTRL);
    assign s_wr     = bus.we && in_range && (rsel == REG_SCTRL);

    // Only the control bits of the store data are meaningful.
    assign unused_din = ^{bus.din[DBITS-1:CTRL_IE+1], bus.din[CTRL_OVR+1], bus.din[CTRL_RDY+1]};

    // Zero-wait read mux; unmapped bits and addresses read as 0.
    always_comb begin
        // NOTE: default first so every path assigns dout_c and no latch is inferred.
        dout_c = '0;
        if (in_range) begin
            unique case (rsel)
                REG_KDATA: dout_c[3:0] = kdata;
                REG_SDATA: dout_c[9:0] = sdata;
                REG_KCTRL: dout_c      = DBITS'(ctrl_word(kctrl));
                REG_SCTRL: dout_c      = DBITS'(ctrl_word(sctrl));
                default:   dout_c      = '0;
            endcase
        end
    end

    assign bus.dout = dout_c;

    assign kctrl_n = ctrl_next(kctrl, k_change, k_rd_clr, k_wr,
                               bus.din[CTRL_RDY], bus.din[CTRL_OVR], bus.din[CTRL_IE]);
    assign sctrl_n = ctrl_next(sctrl, s_change, s_rd_clr, s_wr,
                               bus.din[CTRL_RDY], bus.din[CTRL_OVR], bus.din[CTRL_IE]);

    // Control registers and IRQ; IRQ follows next-state so it rises with RDY.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            kctrl <= '0;
            sctrl <= '0;
            irq   <= 1'b0;
        end else begin
            kctrl <= kctrl_n;
            sctrl <= sctrl_n;
            irq   <= (kctrl_n.rdy & kctrl_n.ie) | (sctrl_n.rdy & sctrl_n.ie);
        end
    end

endmodule

// File: doc/key_sw_dev.md
Name: key_sw_dev

Overview:
- Memory-mapped input-device responder on the CPU data bus. It is the target end of the processor's I/O load/store path.
- Synchronises and debounces KEY[3:0] and SW[9:0], and holds the stable values in data registers.
- Flags each new stable value with a sticky ready bit, and an overrun bit when a value is lost.
- Drives an interrupt request toward the CPU's system-register interrupt logic.
- Replaces the raw combinational KEY/SW read mux at FFF0/FFF2.

Parameters:
- DBITS, 16, bus data/address width.
- DEB_CYCLES, 500000, stable-sample count needed to commit a new value (10 ms at 50 MHz). Minimum 2.
- CBITS, 20, debounce counter width. Must satisfy 2^CBITS > DEB_CYCLES.

Ports:
- CLK  in  1  system clock; all state updates on the posedge.
- RESET_N  in  1  reset, synchronous, active-low.
- ADDR  in  DBITS  data-bus address (CPU M-stage dmemaddr).
- DIN  in  DBITS  store data.
- WE  in  1  store strobe, qualified by ADDR.
- RE  in  1  load strobe (M-stage LW), qualified by ADDR.
- DOUT  out  DBITS  read data, combinational from ADDR.
- SEL  out  1  ADDR hits FFF0..FFF6.
- KEY  in  4  raw push buttons, active-low at the pin.
- SW  in  10  raw switches, asynchronous.
- IRQ  out  1  interrupt request, registered.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low.
- Reset (RESET_N=0 at a posedge) clears everything:
  - sync flops, candidate values, counters;
  - KDATA=0, SDATA=0;
  - KRDY=KOVR=KIE=0, SRDY=SOVR=SIE=0;
  - IRQ=0.
  - Reset mid-debounce discards the pending value.
- After reset, any switch not at 0 produces one change event once debounced. This is intended.
- Input path:
  - KEY is inverted before synchronising, so 1 = pressed.
  - Each bit passes through a 2-flop synchroniser.
- Debounce: one counter and one candidate register per group (keys as one 4-bit group, switches as one 10-bit group).
  - If synced != candidate: candidate<=synced, counter<=0.
  - Else if counter==DEB_CYCLES-1 and candidate != committed value: commit (KDATA/SDATA<=candidate) and raise a change event.
  - Else: counter saturates-increments.
- Latency: a clean pin change shows in KDATA/SDATA exactly DEB_CYCLES+3 posedges after the first edge that samples it. Any bounce restarts the count.
- Register map (DOUT unused bits 0):
  - FFF0 KDATA [3:0]: read-only. RE clears KRDY and KOVR.
  - FFF2 SDATA [9:0]: read-only. RE clears SRDY and SOVR.
  - FFF4 KCTRL: bit0 KRDY, bit2 KOVR, bit4 KIE.
  - FFF6 SCTRL: same layout as KCTRL (SRDY, SOVR, SIE).
- Control-register writes:
  - Writing 0 to RDY or OVR clears it; writing 1 has no effect.
  - IE is plain read/write.
  - Writes to FFF0/FFF2 are ignored.
- Addresses outside FFF0..FFF6: SEL=0, DOUT=0, no side effects.
- Change event:
  - If RDY is already 1 and is not being cleared this cycle: OVR<=1 and RDY stays 1.
  - Otherwise: RDY<=1.
- Simultaneous events:
  - An event in the same cycle as a clearing read or write leaves RDY=1 and OVR unchanged (the new event wins).
  - An IE write in the same cycle as an event: both take effect.
- IRQ is registered: IRQ <= (KRDY&KIE)|(SRDY&SIE), using next-state values. IRQ therefore asserts in the same cycle RDY becomes visible.
- Reads have no side effect when RE=0. A load must assert RE for exactly one cycle.
- Bus timing: DOUT is valid in the same cycle as ADDR (zero-wait). No handshake stall.

Decomposition:
- Shared package holds:
  - register address constants: DEV_KDATA=FFF0, DEV_SDATA=FFF2, DEV_KCTRL=FFF4, DEV_SCTRL=FFF6;
  - CTRL bit positions: RDY=0, OVR=2, IE=4.
- One sub-module: debounce_group, parameterised by width and DEB_CYCLES, containing the synchroniser, candidate, counter, committed value, and a one-cycle change pulse. Instantiated twice.
- Register/IRQ logic stays in key_sw_dev.

Test Plan:
- Reset then idle with KEY=4'hF, SW=0 (DEB_CYCLES=4): DOUT at FFF0 reads 0000, FFF4 reads 0000, IRQ=0 for 20 cycles.
- SW=10'h155 held stable, then read: SDATA=0155 and SRDY=1 exactly 7 edges after the change. RE read of FFF2 returns 0155, and FFF6 then reads 0000.
- KEY[0] bounces 1-0-1-0 every 2 cycles, then holds 0: exactly one commit, 7 edges after the final transition. KDATA=0001, KRDY=1.
- Overrun: SIE=1 (write FFF6<=0010), two switch changes with no read → SCTRL=0015 and IRQ=1. Write FFF6<=0010 → SCTRL=0010 and IRQ=0 one edge later.
- Same-cycle clear and event: RE on FFF0 aligned with the commit edge of a new key value → KRDY=1, KOVR=0, KDATA=new value.
- Reset asserted mid-debounce (counter=2) → no commit after release, and all registers read 0. Sweep WE/RE on FFEE and FFF8 → SEL=0, DOUT=0, no state change.
